// File: rtl/dcache_pkg.sv
// Shared types and address-field geometry for the direct-mapped write-through data cache.
// Field positions are derived from the line count and line length.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int BYTE_W             = 2;
    localparam int DEF_LINES          = 32;
    localparam int DEF_WORDS_PER_LINE = 4;

    function automatic int index_lsb(input int words_per_line);
        return BYTE_W + $clog2(words_per_line);
    endfunction

    function automatic int tag_lsb(input int lines, input int words_per_line);
        return index_lsb(words_per_line) + $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int words_per_line);
        return ADDR_W - tag_lsb(lines, words_per_line);
    endfunction

    localparam int WORD_LSB  = BYTE_W;
    localparam int WORD_W    = $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_LSB = index_lsb(DEF_WORDS_PER_LINE);
    localparam int INDEX_W   = $clog2(DEF_LINES);
    localparam int TAG_LSB   = tag_lsb(DEF_LINES, DEF_WORDS_PER_LINE);
    localparam int TAG_W     = tag_w(DEF_LINES, DEF_WORDS_PER_LINE);

endpackage

// File: rtl/data_cache_array.sv
// Valid/tag/data storage for the data cache: one combinational lookup port,
// a word write port and a tag write port that also marks the line valid.
module data_cache_array
    import dcache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    localparam int INDEX_BITS    = $clog2(LINES),
    localparam int WORD_BITS     = $clog2(WORDS_PER_LINE),
    localparam int TAG_BITS      = tag_w(LINES, WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_BITS-1:0]   rd_tag,
    input  logic [WORD_BITS-1:0]  rd_word,
    output logic                  rd_hit,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  tv_en,
    input  logic [INDEX_BITS-1:0] tv_index,
    input  logic [TAG_BITS-1:0]   tv_tag
);

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES][WORDS_PER_LINE];

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (tv_en) begin
            valid[tv_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bit guards every use.
    always_ff @(posedge clk) begin
        if (tv_en) begin
            tag_mem[tv_index] <= tv_tag;
        end
        if (wr_en) begin
            data_mem[wr_index][wr_word] <= wr_data;
        end
    end

    assign rd_hit  = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_data = data_mem[rd_index][rd_word];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete in the same cycle; misses and all stores stall the core while memory is accessed.
module data_cache_controller
    import dcache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mm_req,
    output logic              mm_we,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic [DATA_W-1:0] mm_rdata,
    input  logic              mm_ack
);

    localparam int CNT_W     = $clog2(WORDS_PER_LINE);
    localparam int LINE_LSB  = index_lsb(WORDS_PER_LINE);
    localparam int LINE_TAG  = tag_lsb(LINES, WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((32'd1 << LINE_LSB) - 32'd1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~32'd3;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  look_addr;
    logic               hit;
    logic [DATA_W-1:0]  hit_data;
    logic               fill_we;
    logic               write_hit_we;
    logic               unused_byte_bits;

    // Outside IDLE the lookup follows the in-flight memory address so a store can update a hit line.
    assign look_addr        = (state == IDLE) ? cpu_addr : mm_addr;
    assign unused_byte_bits = ^look_addr[BYTE_W-1:0];

    assign fill_we      = (state == REFILL) && mm_ack;
    assign write_hit_we = (state == WRITE) && mm_ack && hit;

    data_cache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (look_addr[LINE_TAG-1:LINE_LSB]),
        .rd_tag   (look_addr[ADDR_W-1:LINE_TAG]),
        .rd_word  (look_addr[LINE_LSB-1:BYTE_W]),
        .rd_hit   (hit),
        .rd_data  (hit_data),
        .wr_en    (fill_we || write_hit_we),
        .wr_index (mm_addr[LINE_TAG-1:LINE_LSB]),
        .wr_word  ((state == REFILL) ? cnt : mm_addr[LINE_LSB-1:BYTE_W]),
        .wr_data  ((state == REFILL) ? mm_rdata : mm_wdata),
        .tv_en    (fill_we && (cnt == LAST_WORD)),
        .tv_index (mm_addr[LINE_TAG-1:LINE_LSB]),
        .tv_tag   (mm_addr[ADDR_W-1:LINE_TAG])
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        cpu_rdata  = '0;
        case (state)
            IDLE: begin
                if (cpu_write) begin
                    stall      = 1'b1;
                    state_next = WRITE;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = hit_data;
                    end else begin
                        stall      = 1'b1;
                        state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (mm_ack && (cnt == LAST_WORD)) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                // The core advances on the ack edge, so the ack cycle itself is not stalled.
                stall = !mm_ack;
                if (mm_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mm_req   <= 1'b0;
            mm_we    <= 1'b0;
            mm_addr  <= '0;
            mm_wdata <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        mm_req   <= 1'b1;
                        mm_we    <= 1'b1;
                        mm_addr  <= cpu_addr & WORD_MASK;
                        mm_wdata <= cpu_wdata;
                    end else if (cpu_read && !hit) begin
                        mm_req  <= 1'b1;
                        mm_we   <= 1'b0;
                        mm_addr <= cpu_addr & LINE_MASK;
                        cnt     <= '0;
                    end
                end
                REFILL: begin
                    if (mm_ack) begin
                        cnt     <= cnt + CNT_W'(1);
                        mm_addr <= mm_addr + 32'd4;
                        if (cnt == LAST_WORD) begin
                            mm_req <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (mm_ack) begin
                        mm_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller: per-cycle vector tables plus hand-written
// sequences for a delayed store ack and a reset in the middle of a refill.
module tb_data_cache_controller;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mm_req;
    logic        mm_we;
    logic [31:0] mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;
    logic        mm_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 0;

    data_cache_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mm_req    (mm_req),
        .mm_we     (mm_we),
        .mm_addr   (mm_addr),
        .mm_wdata  (mm_wdata),
        .mm_rdata  (mm_rdata),
        .mm_ack    (mm_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic [31:0] exp_rdata;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    // Main memory: initial contents come from a fixed pattern, stores overwrite it.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] init_data(input logic [31:0] a);
        logic [31:0] w;
        if (a[31:4] == 28'h4) begin
            w = {30'd0, a[3:2]} + 32'd1;
            return w * 32'h11;
        end
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: acks after ack_delay cycles of a held request.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mm_ack   = 1'b0;
        mm_rdata = '0;
        forever begin
            @(negedge clk);
            mm_ack = 1'b0;
            if (mm_req && reset) begin
                if (wait_cnt >= ack_delay) begin
                    mm_ack   = 1'b1;
                    mm_rdata = mem.exists(mm_addr) ? mem[mm_addr] : init_data(mm_addr);
                    if (mm_we) mem[mm_addr] = mm_wdata;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic st, input logic [31:0] rdata, input logic req, input logic we,
                       input logic [31:0] maddr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_stall = st; v.exp_rdata = rdata; v.exp_req = req; v.exp_we = we; v.exp_addr = maddr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #2;
            check($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d mm_req", i), {31'd0, mm_req}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) begin
                check($sformatf("v%0d mm_we", i), {31'd0, mm_we}, {31'd0, vecs[i].exp_we});
                check($sformatf("v%0d mm_addr", i), mm_addr, vecs[i].exp_addr);
            end
        end
    endtask

    initial begin
        int waits;

        // Table A: cold miss on 0x48, refill, then same-cycle hits.
        add(1, 0, 32'h48, 0, 1, 32'h0,  0, 0, 32'h0);      // 0 detect miss
        add(1, 0, 32'h48, 0, 1, 32'h0,  1, 0, 32'h40);     // 1
        add(1, 0, 32'h48, 0, 1, 32'h0,  1, 0, 32'h44);     // 2
        add(1, 0, 32'h48, 0, 1, 32'h0,  1, 0, 32'h48);     // 3
        add(1, 0, 32'h48, 0, 1, 32'h0,  1, 0, 32'h4C);     // 4 last ack
        add(1, 0, 32'h48, 0, 0, 32'h33, 0, 0, 32'h0);      // 5 retried read hits
        add(1, 0, 32'h44, 0, 0, 32'h22, 0, 0, 32'h0);      // 6
        add(0, 0, 32'h44, 0, 0, 32'h0,  0, 0, 32'h0);      // 7 no request
        add(1, 0, 32'h40, 0, 0, 32'h11, 0, 0, 32'h0);      // 8
        add(1, 0, 32'h4C, 0, 0, 32'h44, 0, 0, 32'h0);      // 9
        // Table B: store hit result, write miss with read+write both high, line replacement.
        add(1, 0, 32'h4C,   0, 0, 32'hDEADBEEF, 0, 0, 32'h0);                // 10
        add(1, 0, 32'h48,   0, 0, 32'h33,       0, 0, 32'h0);                // 11
        add(1, 1, 32'h1000, 32'h12345678, 1, 32'h0, 0, 0, 32'h0);            // 12 treated as write
        add(1, 1, 32'h1000, 32'h12345678, 0, 32'h0, 1, 1, 32'h1000);         // 13 ack cycle
        add(1, 0, 32'h1000, 0, 1, 32'h0, 0, 0, 32'h0);                       // 14 no allocation
        add(1, 0, 32'h1000, 0, 1, 32'h0, 1, 0, 32'h1000);                    // 15
        add(1, 0, 32'h1000, 0, 1, 32'h0, 1, 0, 32'h1004);                    // 16
        add(1, 0, 32'h1000, 0, 1, 32'h0, 1, 0, 32'h1008);                    // 17
        add(1, 0, 32'h1000, 0, 1, 32'h0, 1, 0, 32'h100C);                    // 18
        add(1, 0, 32'h1000, 0, 0, 32'h12345678, 0, 0, 32'h0);                // 19
        add(1, 0, 32'h1008, 0, 0, 32'h5A5A1008, 0, 0, 32'h0);                // 20
        add(1, 0, 32'h240,  0, 1, 32'h0, 0, 0, 32'h0);                       // 21 index 4, new tag
        add(1, 0, 32'h240,  0, 1, 32'h0, 1, 0, 32'h240);                     // 22
        add(1, 0, 32'h240,  0, 1, 32'h0, 1, 0, 32'h244);                     // 23
        add(1, 0, 32'h240,  0, 1, 32'h0, 1, 0, 32'h248);                     // 24
        add(1, 0, 32'h240,  0, 1, 32'h0, 1, 0, 32'h24C);                     // 25
        add(1, 0, 32'h244,  0, 0, 32'h5A5A0244, 0, 0, 32'h0);                // 26
        add(1, 0, 32'h40,   0, 1, 32'h0, 0, 0, 32'h0);                       // 27 evicted
        add(1, 0, 32'h40,   0, 1, 32'h0, 1, 0, 32'h40);                      // 28 ack 1
        add(1, 0, 32'h40,   0, 1, 32'h0, 1, 0, 32'h44);                      // 29 ack 2
        // Table C: after reset the line is invalid and the refill restarts at 0x40.
        add(1, 0, 32'h40, 0, 1, 32'h0, 0, 0, 32'h0);                         // 30
        add(1, 0, 32'h40, 0, 1, 32'h0, 1, 0, 32'h40);                        // 31
        add(1, 0, 32'h40, 0, 1, 32'h0, 1, 0, 32'h44);                        // 32
        add(1, 0, 32'h40, 0, 1, 32'h0, 1, 0, 32'h48);                        // 33
        add(1, 0, 32'h40, 0, 1, 32'h0, 1, 0, 32'h4C);                        // 34
        add(1, 0, 32'h40, 0, 0, 32'h11, 0, 0, 32'h0);                        // 35
        add(1, 0, 32'h4C, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0);                  // 36 written-through value

        // Reset state with a load pending: every line invalid, so stall is high.
        reset = 1'b0;
        drive(1, 0, 32'h48, 32'h0);
        #2;
        check("reset stall", {31'd0, stall}, 32'd1);
        check("reset mm_req", {31'd0, mm_req}, 32'd0);
        check("reset mm_we", {31'd0, mm_we}, 32'd0);
        check("reset mm_addr", mm_addr, 32'h0);
        check("reset mm_wdata", mm_wdata, 32'h0);
        check("reset cpu_rdata", cpu_rdata, 32'h0);
        repeat (2) @(negedge clk);
        drive(0, 0, 32'h0, 32'h0);
        reset = 1'b1;

        run_vectors(0, 9);

        // Store to 0x4C with three idle request cycles before the ack.
        ack_delay = 3;
        @(negedge clk);
        drive(0, 1, 32'h4C, 32'hDEADBEEF);
        #2;
        check("wr detect stall", {31'd0, stall}, 32'd1);
        check("wr detect mm_req", {31'd0, mm_req}, 32'd0);
        waits = 0;
        for (int i = 0; i < 8 && !mm_ack; i++) begin
            @(negedge clk);
            #2;
            if (!mm_ack) begin
                waits++;
                check("wr wait stall", {31'd0, stall}, 32'd1);
                check("wr wait mm_we", {31'd0, mm_we}, 32'd1);
                check("wr wait mm_addr", mm_addr, 32'h4C);
                check("wr wait mm_wdata", mm_wdata, 32'hDEADBEEF);
            end
        end
        check("wr ack seen", {31'd0, mm_ack}, 32'd1);
        check("wr wait cycles", waits, 32'd3);
        check("wr ack stall", {31'd0, stall}, 32'd0);
        check("wr ack mm_we", {31'd0, mm_we}, 32'd1);
        check("wr ack mm_addr", mm_addr, 32'h4C);
        ack_delay = 0;

        run_vectors(10, 29);

        // Reset after two refill acks: mm_req must drop without waiting for a clock edge.
        @(negedge clk);
        #1;
        check("abort pre mm_req", {31'd0, mm_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort mm_req", {31'd0, mm_req}, 32'd0);
        check("abort mm_addr", mm_addr, 32'h0);
        check("abort stall", {31'd0, stall}, 32'd1);
        check("abort cpu_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 32'h0);
        reset = 1'b1;

        run_vectors(30, 36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
